// File: rtl/dma_dst_wr_engine.sv
// DMA destination write engine: pulls lane-aligned beats from a buffer and
// issues byte-enabled bus writes covering an arbitrary byte range.
module dma_dst_wr_engine #(
   parameter int DATA_WD = 32,
   parameter int ADDR_WD = 32,
   parameter int LEN_WD  = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [ADDR_WD-1:0]   dst_addr_i,
   input  logic [LEN_WD-1:0]    data_length_i,
   input  logic [DATA_WD-1:0]   buf_rdata_i,
   input  logic                 buf_rvalid_i,
   output logic                 buf_rready_o,
   output logic                 bus_req_o,
   input  logic                 bus_gnt_i,
   output logic [ADDR_WD-1:0]   bus_addr_o,
   output logic [DATA_WD/8-1:0] bus_be_o,
   output logic [DATA_WD-1:0]   bus_wdata_o,
   output logic                 bus_we_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [LEN_WD-1:0]    bytes_done_o
);

   localparam int BE_WD  = DATA_WD / 8;
   localparam int OFS_WD = $clog2(BE_WD);
   localparam int CNT_WD = OFS_WD + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_REQ,
      ST_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_WD-1:0]  addr_q, addr_d;
   logic [OFS_WD-1:0]   ofs_q, ofs_d;
   logic [LEN_WD-1:0]   rem_q, rem_d;
   logic [LEN_WD-1:0]   bytes_q, bytes_d;
   logic [BE_WD-1:0]    be_q, be_d;
   logic [CNT_WD-1:0]   cnt_q, cnt_d;
   logic [DATA_WD-1:0]  wdata_q, wdata_d;
   logic                err_q, err_d;

   logic [CNT_WD-1:0]   avail;
   logic [CNT_WD-1:0]   beat_cnt;
   logic [BE_WD-1:0]    beat_be;

   // Byte count and enables of the beat being fetched. ofs_q is non-zero only
   // for the first beat of a transfer, so later beats start at lane 0.
   always_comb begin
      beat_be = '0;
      avail   = CNT_WD'(BE_WD) - {1'b0, ofs_q};
      if (rem_q < LEN_WD'(avail)) begin
         beat_cnt = rem_q[CNT_WD-1:0];
      end else begin
         beat_cnt = avail;
      end
      for (int i = 0; i < BE_WD; i++) begin
         beat_be[i] = (i >= int'(ofs_q)) && (i < int'(ofs_q) + int'(beat_cnt));
      end
   end

   // NOTE: every always_comb target gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ofs_d   = ofs_q;
      rem_d   = rem_q;
      bytes_d = bytes_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      err_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (data_length_i != '0) begin
                  state_d = ST_FETCH;
                  addr_d  = {dst_addr_i[ADDR_WD-1:OFS_WD], {OFS_WD{1'b0}}};
                  ofs_d   = dst_addr_i[OFS_WD-1:0];
                  rem_d   = data_length_i;
                  bytes_d = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_FETCH: begin
            if (abort_i) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (buf_rvalid_i) begin
               state_d = ST_REQ;
               wdata_d = buf_rdata_i;
               be_d    = beat_be;
               cnt_d   = beat_cnt;
            end
         end

         ST_REQ: begin
            // A grant coinciding with abort still counts: the bus took the beat.
            if (bus_gnt_i) begin
               bytes_d = bytes_q + LEN_WD'(cnt_q);
               rem_d   = rem_q - LEN_WD'(cnt_q);
               addr_d  = addr_q + ADDR_WD'(BE_WD);
               ofs_d   = '0;
            end
            if (abort_i) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (bus_gnt_i) begin
               state_d = (rem_q == LEN_WD'(cnt_q)) ? ST_DONE : ST_FETCH;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the beat data/enable registers are reset too, because they drive bus outputs
   // that must read 0 in reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         ofs_q   <= '0;
         rem_q   <= '0;
         bytes_q <= '0;
         be_q    <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ofs_q   <= ofs_d;
         rem_q   <= rem_d;
         bytes_q <= bytes_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   // Handshake outputs decode the state register only, keeping bus_gnt_i
   // off any combinational path to buf_rready_o.
   assign buf_rready_o = (state_q == ST_FETCH);
   assign bus_req_o    = (state_q == ST_REQ);
   assign bus_addr_o   = addr_q;
   assign bus_be_o     = be_q;
   assign bus_wdata_o  = wdata_q;
   assign bus_we_o     = 1'b1;
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_DONE);
   assign err_o        = err_q;
   assign bytes_done_o = bytes_q;

endmodule
